// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/load sources in, register-file write ports and LQ status out.
// Defining WB_STATS_EN adds the stat_stall / stat_kill counter outputs.
interface wb_arbiter_if #(
    parameter int LQ_DEPTH = 4
);
    logic                      alu1_valid;
    logic [4:0]                alu1_rd;
    logic [31:0]               alu1_data;
    logic                      alu2_valid;
    logic [4:0]                alu2_rd;
    logic [31:0]               alu2_data;
    logic                      ld_valid;
    logic [4:0]                ld_rd;
    logic [31:0]               ld_data;
    logic                      ld_ready;
    logic                      reg_write;
    logic [4:0]                regd;
    logic [31:0]               write_data;
    logic                      reg_write2;
    logic [4:0]                regd2;
    logic [31:0]               write_data2;
    logic [31:0]               busy_mask;
    logic [$clog2(LQ_DEPTH):0] lq_count;
`ifdef WB_STATS_EN
    logic [31:0]               stat_stall;
    logic [31:0]               stat_kill;

    modport slave (
        input  alu1_valid, alu1_rd, alu1_data, alu2_valid, alu2_rd, alu2_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
        output busy_mask, lq_count, stat_stall, stat_kill
    );
    modport master (
        output alu1_valid, alu1_rd, alu1_data, alu2_valid, alu2_rd, alu2_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
        input  busy_mask, lq_count, stat_stall, stat_kill
    );
`else
    modport slave (
        input  alu1_valid, alu1_rd, alu1_data, alu2_valid, alu2_rd, alu2_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
        output busy_mask, lq_count
    );
    modport master (
        output alu1_valid, alu1_rd, alu1_data, alu2_valid, alu2_rd, alu2_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready, reg_write, regd, write_data, reg_write2, regd2, write_data2,
        input  busy_mask, lq_count
    );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two ALU pipes plus a load queue merged onto two register-file write ports,
// with WAW kills of stale loads. Optional counters enabled by defining WB_STATS_EN.
module wb_arbiter #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]          rd_q   [LQ_DEPTH];
    logic [4:0]          rd_d   [LQ_DEPTH];
    logic [31:0]         data_q [LQ_DEPTH];
    logic [31:0]         data_d [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [31:0]         busy_q, busy_d;
    logic                rw1_q, rw1_d, rw2_q, rw2_d;
    logic [4:0]          rd1_q, rd1_d, rd2_q, rd2_d;
    logic [31:0]         wd1_q, wd1_d, wd2_q, wd2_d;

    logic                eff1, eff2, full, enq, enq_live, take1, take2;
    logic [PW-1:0]       src2_ptr, off_n;
    logic [CW-1:0]       npop, kill_cnt;
    logic [LQ_DEPTH-1:0] hit;

    // Port allocation: ALUs own their ports, free ports pop from the LQ head in order.
    always_comb begin
        eff1     = bus.alu1_valid && (bus.alu1_rd != 5'd0);
        eff2     = bus.alu2_valid && (bus.alu2_rd != 5'd0);
        full     = (count_q == CW'(LQ_DEPTH));
        enq      = bus.ld_valid && !full && (bus.ld_rd != 5'd0);
        enq_live = !((eff1 && bus.ld_rd == bus.alu1_rd) || (eff2 && bus.ld_rd == bus.alu2_rd));
        take1    = !eff1 && (count_q != '0);
        take2    = 1'b0;
        if (!eff2) begin
            take2 = take1 ? (count_q >= CW'(2)) : (count_q != '0);
        end
        src2_ptr = take1 ? head_q + PW'(1) : head_q;
        npop     = CW'(take1) + CW'(take2);

        rw1_d = 1'b0;
        rd1_d = 5'd0;
        wd1_d = 32'd0;
        if (eff1) begin
            if (!(eff2 && bus.alu1_rd == bus.alu2_rd)) begin
                rw1_d = 1'b1;
                rd1_d = bus.alu1_rd;
                wd1_d = bus.alu1_data;
            end
        end else if (take1 && live_q[head_q]) begin
            rw1_d = 1'b1;
            rd1_d = rd_q[head_q];
            wd1_d = data_q[head_q];
        end

        rw2_d = 1'b0;
        rd2_d = 5'd0;
        wd2_d = 32'd0;
        if (eff2) begin
            rw2_d = 1'b1;
            rd2_d = bus.alu2_rd;
            wd2_d = bus.alu2_data;
        end else if (take2 && live_q[src2_ptr]) begin
            rw2_d = 1'b1;
            rd2_d = rd_q[src2_ptr];
            wd2_d = data_q[src2_ptr];
        end
    end

    // A slot is killed when it is occupied, not popped this cycle, live, and overwritten by an ALU.
    for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_slot
        logic [PW-1:0] off;
        assign off     = PW'(gi) - head_q;
        assign hit[gi] = ({1'b0, off} < count_q) && ({1'b0, off} >= npop) && live_q[gi] &&
                         ((eff1 && rd_q[gi] == bus.alu1_rd) || (eff2 && rd_q[gi] == bus.alu2_rd));
    end

    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        live_d   = live_q & ~hit;
        kill_cnt = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            kill_cnt = kill_cnt + CW'(hit[i]);
        end
        if (enq) begin
            rd_d[tail_q]   = bus.ld_rd;
            data_d[tail_q] = bus.ld_data;
            live_d[tail_q] = enq_live;
            if (!enq_live) begin
                kill_cnt = kill_cnt + CW'(1);
            end
        end
        head_d  = head_q + PW'(npop);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q - npop + CW'(enq);

        busy_d = 32'd0;
        off_n  = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            off_n = PW'(i) - head_d;
            if (({1'b0, off_n} < count_d) && live_d[i]) begin
                busy_d[rd_d[i]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            rw1_q   <= 1'b0;
            rd1_q   <= 5'd0;
            wd1_q   <= 32'd0;
            rw2_q   <= 1'b0;
            rd2_q   <= 5'd0;
            wd2_q   <= 32'd0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            rw1_q   <= rw1_d;
            rd1_q   <= rd1_d;
            wd1_q   <= wd1_d;
            rw2_q   <= rw2_d;
            rd2_q   <= rd2_d;
            wd2_q   <= wd2_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by head/count and live bits.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    assign bus.ld_ready    = !full;
    assign bus.reg_write   = rw1_q;
    assign bus.regd        = rd1_q;
    assign bus.write_data  = wd1_q;
    assign bus.reg_write2  = rw2_q;
    assign bus.regd2       = rd2_q;
    assign bus.write_data2 = wd2_q;
    assign bus.busy_mask   = busy_q;
    assign bus.lq_count    = count_q;

`ifdef WB_STATS_EN
    logic [31:0] stall_q, stall_d, kills_q, kills_d;

    always_comb begin
        stall_d = stall_q + 32'(bus.ld_valid && full);
        kills_d = kills_q + 32'(kill_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
            kills_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
            kills_q <= kills_d;
        end
    end

    assign bus.stat_stall = stall_q;
    assign bus.stat_kill  = kills_q;
`endif
endmodule
